// File: rtl/prog_sequence_generator_if.sv
// prog_sequence_generator_if: playback control, table write and output bundle
interface prog_sequence_generator_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  parameter int AW = $clog2(DEPTH)
);
  logic enable;
  logic restart;
  logic [1:0] mode;
  logic [AW-1:0] last;
  logic wr_en;
  logic [AW-1:0] wr_addr;
  logic [WIDTH-1:0] wr_data;
  logic [WIDTH-1:0] data;
  logic [AW-1:0] index;
  logic done;
  modport master (output enable, restart, mode, last, wr_en, wr_addr, wr_data, input data, index, done);
  modport slave (input enable, restart, mode, last, wr_en, wr_addr, wr_data, output data, index, done);
endinterface

// File: rtl/prog_sequence_generator.sv
// prog_sequence_generator: programmable table playback in loop, one-shot or ping-pong order
module prog_sequence_generator #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  parameter int AW = $clog2(DEPTH)
) (
  input logic clock,
  input logic reset,
  prog_sequence_generator_if.slave bus
);
  typedef enum logic [1:0] {LOOP = 2'b00, ONESHOT = 2'b01, PINGPONG = 2'b10, HOLD = 2'b11} mode_t;
  logic [WIDTH-1:0] table_q [DEPTH];
  logic [WIDTH-1:0] data_q, data_d;
  logic [AW-1:0] idx_q, idx_d;
  logic dir_q, dir_d, done_q, done_d, adv, at_end;
  mode_t mode;
  assign mode = mode_t'(bus.mode);
  assign bus.data = data_q;
  assign bus.index = idx_q;
  assign bus.done = done_q;
  // restart wins over advance; an advance plays table[idx] then steps idx/dir for the mode
  always_comb begin
    adv = bus.enable && mode != HOLD && !done_q && !bus.restart;
    at_end = idx_q >= bus.last;
    data_d = data_q;
    idx_d = idx_q;
    dir_d = dir_q;
    done_d = done_q;
    if (bus.restart) begin
      idx_d = '0;
      dir_d = 1'b0;
      done_d = 1'b0;
    end else if (adv) begin
      data_d = table_q[idx_q];
      dir_d = 1'b0;
      if (mode == LOOP) idx_d = at_end ? '0 : idx_q + 1'b1;
      else if (mode == ONESHOT) begin
        idx_d = at_end ? idx_q : idx_q + 1'b1;
        done_d = at_end;
      end else if (bus.last == '0) idx_d = '0;
      else if (!dir_q) begin
        idx_d = at_end ? bus.last - 1'b1 : idx_q + 1'b1;
        dir_d = at_end;
      end else begin
        idx_d = idx_q == '0 ? AW'(1) : idx_q - 1'b1;
        dir_d = idx_q != '0;
      end
    end
  end
  // state registers; table writes are independent of playback and see the pre-write value on a same-edge read
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) table_q[i] <= '0;
      data_q <= '0;
      idx_q <= '0;
      dir_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      if (bus.wr_en) table_q[bus.wr_addr] <= bus.wr_data;
      data_q <= data_d;
      idx_q <= idx_d;
      dir_q <= dir_d;
      done_q <= done_d;
    end
  end
endmodule
